md_sequencer: RTL and testbench

// Multi-cycle multiply/divide sequencer owning the HI/LO register pair. Sits in EX, fed by
// the decoder's md/alu_md/op_mthi/op_mtlo/op_mfhi/op_mflo strobes and forwarded rs/rt operands.

---
 rtl/md_sequencer_if.sv | 29 ++
 rtl/md_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_md_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// Handshake bundle between the EX-stage decoder strobes and the multiply/divide sequencer.
// The decoder side drives instruction strobes and operands; the sequencer returns interlock and HI/LO state.
interface md_sequencer_if;
    logic        md;
    logic [1:0]  alu_md;
    logic        op_mthi;
    logic        op_mtlo;
    logic        op_mfhi;
    logic        op_mflo;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata;
    logic        div_zero;

    modport master (
        output md, alu_md, op_mthi, op_mtlo, op_mfhi, op_mflo, flush, rs_data, rt_data,
        input  stall, busy, hi, lo, hilo_rdata, div_zero
    );

    modport slave (
        input  md, alu_md, op_mthi, op_mtlo, op_mfhi, op_mflo, flush, rs_data, rt_data,
        output stall, busy, hi, lo, hilo_rdata, div_zero
    );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; runs ops in the background and
// interlocks later HI/LO or md instructions while an operation is in flight.
module md_sequencer #(
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    md_sequencer_if.slave bus
);

    // Counter must hold both the divide iteration count and MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 33) ? $clog2(MUL_LAT) : 6;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(32);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           state_r;
    logic             busy_r;
    logic             div_zero_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      opa_r;
    logic [31:0]      opb_r;
    logic [31:0]      rem_r;
    logic             sign_r;
    logic             neg_q_r;
    logic             neg_rem_r;

    logic             req_s;
    logic             stall_s;
    logic             div_signed_s;
    logic [63:0]      ext_a_s;
    logic [63:0]      ext_b_s;
    logic [63:0]      prod_s;
    logic [32:0]      shift_s;
    logic [31:0]      rem_nxt_s;
    logic [31:0]      quo_nxt_s;
    logic [31:0]      rdata_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    assign req_s        = bus.md | bus.op_mthi | bus.op_mtlo | bus.op_mfhi | bus.op_mflo;
    assign stall_s      = busy_r & req_s & ~bus.flush;
    assign div_signed_s = ~bus.alu_md[0];

    // Sign-extending both operands lets one 64-bit multiplier serve mult and multu.
    assign ext_a_s = {{32{sign_r & opa_r[31]}}, opa_r};
    assign ext_b_s = {{32{sign_r & opb_r[31]}}, opb_r};
    assign prod_s  = ext_a_s * ext_b_s;

    // One restoring-division step: opa_r shifts out dividend bits and shifts in quotient bits.
    always_comb begin
        shift_s   = {rem_r, opa_r[31]};
        rem_nxt_s = shift_s[31:0];
        quo_nxt_s = {opa_r[30:0], 1'b0};
        if (shift_s >= {1'b0, opb_r}) begin
            rem_nxt_s = shift_s[31:0] - opb_r;
            quo_nxt_s = {opa_r[30:0], 1'b1};
        end else begin
            rem_nxt_s = shift_s[31:0];
            quo_nxt_s = {opa_r[30:0], 1'b0};
        end
    end

    // HI/LO read mux; mfhi wins when both reads are strobed.
    always_comb begin
        rdata_s = 32'd0;
        if (bus.op_mfhi) begin
            rdata_s = hi_r;
        end else if (bus.op_mflo) begin
            rdata_s = lo_r;
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Sequencer FSM: accepts ops, iterates, writes HI/LO, handles flush and mt* writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            div_zero_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            opa_r      <= 32'd0;
            opb_r      <= 32'd0;
            rem_r      <= 32'd0;
            sign_r     <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.md && !bus.flush) begin
                        if (!bus.alu_md[1]) begin
                            state_r <= ST_MUL;
                            busy_r  <= 1'b1;
                            cnt_r   <= MUL_LAST;
                            opa_r   <= bus.rs_data;
                            opb_r   <= bus.rt_data;
                            sign_r  <= ~bus.alu_md[0];
                        end else if (bus.rt_data == 32'd0) begin
                            div_zero_r <= 1'b1;
                        end else begin
                            state_r   <= ST_DIV;
                            busy_r    <= 1'b1;
                            cnt_r     <= DIV_ITERS;
                            opa_r     <= abs32(bus.rs_data, div_signed_s);
                            opb_r     <= abs32(bus.rt_data, div_signed_s);
                            rem_r     <= 32'd0;
                            neg_q_r   <= div_signed_s & (bus.rs_data[31] ^ bus.rt_data[31]);
                            neg_rem_r <= div_signed_s & bus.rs_data[31];
                        end
                    end else if (!bus.flush) begin
                        if (bus.op_mthi) begin
                            hi_r <= bus.rs_data;
                        end
                        if (bus.op_mtlo) begin
                            lo_r <= bus.rs_data;
                        end
                    end
                end
                ST_MUL: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_ZERO) begin
                        hi_r    <= prod_s[63:32];
                        lo_r    <= prod_s[31:0];
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DIV: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r != CNT_ZERO) begin
                        opa_r <= quo_nxt_s;
                        rem_r <= rem_nxt_s;
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        // Fixup: 0x80000000 / -1 negates to itself, which is the wrapped result.
                        lo_r    <= neg_q_r   ? neg32(opa_r) : opa_r;
                        hi_r    <= neg_rem_r ? neg32(rem_r) : rem_r;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.stall      = stall_s;
    assign bus.busy       = busy_r;
    assign bus.hi         = hi_r;
    assign bus.lo         = lo_r;
    assign bus.hilo_rdata = rdata_s;
    assign bus.div_zero   = div_zero_r;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: a driver issues instructions and pushes expected results
// from an architectural model; a monitor pops and compares as the DUT completes or reads.
module tb_md_sequencer;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md_sequencer_if bus();

    md_sequencer #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        dz;
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } item_t;

    item_t       res_q[$];
    logic [31:0] rd_q[$];
    item_t       mon_it;
    logic [31:0] mon_rd;
    int          mon_len = 0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          busy_end = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural reference: results computed directly from the operation's definition.
    function automatic void model_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rhi, output logic [31:0] rlo, output int len);
        longint      la;
        longint      lb;
        logic [63:0] p;
        int          sa;
        int          sb;
        rhi = 32'd0;
        rlo = 32'd0;
        len = op[1] ? DIV_LAT : MUL_LAT;
        case (op)
            2'b00: begin
                la = $signed(a);
                lb = $signed(b);
                p = 64'(la * lb);
                {rhi, rlo} = p;
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                {rhi, rlo} = p;
            end
            2'b10: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rlo = 32'h8000_0000;
                    rhi = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    rlo = 32'(sa / sb);
                    rhi = 32'(sa % sb);
                end
            end
            default: begin
                rlo = a / b;
                rhi = a % b;
            end
        endcase
    endfunction

    task automatic clear_inputs();
        bus.md = 1'b0; bus.alu_md = 2'b00; bus.op_mthi = 1'b0; bus.op_mtlo = 1'b0;
        bus.op_mfhi = 1'b0; bus.op_mflo = 1'b0; bus.flush = 1'b0;
        bus.rs_data = 32'd0; bus.rt_data = 32'd0;
    endtask

    // abort_kind: 0 none, 1 flush on busy cycle abort_at, 2 reset on busy cycle abort_at.
    task automatic do_instr(input logic i_md, input logic [1:0] i_alu, input logic i_mthi, input logic i_mtlo,
                            input logic i_mfhi, input logic i_mflo, input logic [31:0] i_rs, input logic [31:0] i_rt,
                            input int abort_at, input int abort_kind);
        int          p;
        int          ns;
        int          exp_ns;
        int          len;
        logic        done;
        logic [31:0] rhi;
        logic [31:0] rlo;
        item_t       it;
        p = cyc;
        bus.md = i_md; bus.alu_md = i_alu; bus.op_mthi = i_mthi; bus.op_mtlo = i_mtlo;
        bus.op_mfhi = i_mfhi; bus.op_mflo = i_mflo; bus.flush = 1'b0;
        bus.rs_data = i_rs; bus.rt_data = i_rt;
        if (i_mfhi || i_mflo) rd_q.push_back(i_mfhi ? m_hi : m_lo);
        exp_ns = (busy_end > p) ? (busy_end - p) : 0;
        ns = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.stall !== 1'b1 || ns > 200) done = 1'b1;
            else ns++;
        end
        chk("stall_cycles", 64'(ns), 64'(exp_ns));
        @(posedge clk);
        #1;
        clear_inputs();
        if (i_md) begin
            if (i_alu[1] && i_rt == 32'd0) begin
                it.dz = 1'b1; it.len = 0; it.hi = m_hi; it.lo = m_lo;
                res_q.push_back(it);
            end else begin
                model_md(i_alu, i_rs, i_rt, rhi, rlo, len);
                it.dz = 1'b0;
                if (abort_kind != 0) begin
                    it.len = abort_at;
                    if (abort_kind == 2) begin
                        m_hi = 32'd0;
                        m_lo = 32'd0;
                    end
                end else begin
                    it.len = len;
                    m_hi = rhi;
                    m_lo = rlo;
                end
                it.hi = m_hi; it.lo = m_lo;
                res_q.push_back(it);
                busy_end = cyc + it.len;
                if (abort_kind != 0) begin
                    repeat (abort_at - 1) begin
                        @(posedge clk);
                        #1;
                    end
                    if (abort_kind == 2) rst = 1'b1;
                    else bus.flush = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    bus.flush = 1'b0;
                end
            end
        end else begin
            if (i_mthi) m_hi = i_rs;
            if (i_mtlo) m_lo = i_rs;
        end
    endtask

    // A flushed instruction in an idle cycle must leave no trace.
    task automatic do_masked(input logic i_md, input logic [1:0] i_alu, input logic i_mthi, input logic i_mtlo,
                             input logic [31:0] i_rs, input logic [31:0] i_rt);
        int guard;
        guard = 0;
        while (cyc < busy_end && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        bus.md = i_md; bus.alu_md = i_alu; bus.op_mthi = i_mthi; bus.op_mtlo = i_mtlo;
        bus.rs_data = i_rs; bus.rt_data = i_rt; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic wait_idle_check(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int guard;
        guard = 0;
        while (cyc < busy_end && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        chk({nm, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops expectations as completions, div-by-zero pulses and HI/LO reads appear.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            mon_len++;
        end else if (mon_len > 0) begin
            if (res_q.size() == 0) begin
                chk("unexpected_completion", 64'(mon_len), 64'd0);
            end else begin
                mon_it = res_q.pop_front();
                chk("completion_kind", 64'(0), 64'(mon_it.dz));
                chk("busy_len", 64'(mon_len), 64'(mon_it.len));
                chk("result_hi", 64'(bus.hi), 64'(mon_it.hi));
                chk("result_lo", 64'(bus.lo), 64'(mon_it.lo));
            end
            mon_len = 0;
        end
        if (bus.div_zero === 1'b1) begin
            if (res_q.size() == 0) begin
                chk("unexpected_div_zero", 64'd1, 64'd0);
            end else begin
                mon_it = res_q.pop_front();
                chk("div_zero_kind", 64'(1), 64'(mon_it.dz));
                chk("div_zero_busy", 64'(bus.busy), 64'd0);
                chk("div_zero_hi", 64'(bus.hi), 64'(mon_it.hi));
                chk("div_zero_lo", 64'(bus.lo), 64'(mon_it.lo));
            end
        end
        if (bus.stall === 1'b0 && (bus.op_mfhi === 1'b1 || bus.op_mflo === 1'b1)) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_read", 64'(bus.hilo_rdata), 64'd0);
            end else begin
                mon_rd = rd_q.pop_front();
                chk("hilo_rdata", 64'(bus.hilo_rdata), 64'(mon_rd));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  t;
        int          len;
        int          ab;
        int          kind;

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_div_zero", 64'(bus.div_zero), 64'd0);
        chk("reset_rdata", 64'(bus.hilo_rdata), 64'd0);
        @(posedge clk);
        #1;

        do_instr(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 0);
        wait_idle_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_instr(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 0);
        wait_idle_check("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        do_instr(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_instr(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 0, 0);
        wait_idle_check("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_instr(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd2, 0, 0);
        wait_idle_check("divu", 32'd1, 32'd3);
        do_instr(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        wait_idle_check("div_ovf", 32'd0, 32'h8000_0000);

        do_instr(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 0, 0);
        do_instr(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 10, 1);
        wait_idle_check("div_flush", 32'h55, 32'h55);
        do_instr(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 0, 0);
        wait_idle_check("div_by_zero", 32'h55, 32'h55);

        do_instr(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd0, 0, 0);
        do_instr(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 0, 0);
        do_instr(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 2, 2);
        wait_idle_check("reset_mid_mult", 32'd0, 32'd0);

        do_instr(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 0, 0);
        do_instr(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 0, 0);
        do_instr(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, MUL_LAT, 1);
        do_instr(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd4, DIV_LAT, 1);
        do_masked(1'b1, 2'b10, 1'b0, 1'b0, 32'd5, 32'd0);
        do_masked(1'b0, 2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd0);
        wait_idle_check("masked", 32'd0, 32'd42);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    op = 2'($urandom_range(0, 3));
                    a = pick();
                    b = pick();
                    len = op[1] ? DIV_LAT : MUL_LAT;
                    ab = 0;
                    kind = 0;
                    if ($urandom_range(0, 7) == 0) begin
                        ab = $urandom_range(1, len);
                        kind = ($urandom_range(0, 3) == 0) ? 2 : 1;
                    end
                    do_instr(1'b1, op, 1'b0, 1'b0, 1'b0, 1'b0, a, b, ab, kind);
                end
                4: begin
                    t = 2'($urandom_range(1, 3));
                    do_instr(1'b0, 2'b00, t[0], t[1], 1'b0, 1'b0, $urandom, 32'd0, 0, 0);
                end
                5, 6, 7: begin
                    t = 2'($urandom_range(1, 3));
                    do_instr(1'b0, 2'b00, 1'b0, 1'b0, t[0], t[1], 32'd0, 32'd0, 0, 0);
                end
                8: begin
                    t = 2'($urandom_range(0, 3));
                    do_masked(t[0], 2'($urandom_range(0, 3)), t[1], ~t[0], pick(), pick());
                end
                default: begin
                    op = 2'($urandom_range(0, 3));
                    do_instr(1'b1, op, 1'b1, 1'b1, 1'b0, 1'b0, pick(), pick(), 0, 0);
                end
            endcase
        end

        wait_idle_check("final", m_hi, m_lo);
        repeat (5) @(posedge clk);
        chk("result_queue_drained", 64'(res_q.size()), 64'd0);
        chk("read_queue_drained", 64'(rd_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
